// File: rtl/ixc_assign_pkg.sv
// Shared types and constants for the registered force/release/deposit assign block.
// Also holds the saturating increment used by the change counter.
package ixc_assign_pkg;

  localparam int IXC_CHG_CNT_W = 16;
  localparam logic [IXC_CHG_CNT_W-1:0] IXC_CHG_CNT_MAX = '1;

  typedef enum logic [0:0] {
    PASS  = 1'b0,
    FORCE = 1'b1
  } ixc_fr_state_e;

  function automatic logic [IXC_CHG_CNT_W-1:0] ixc_sat_inc(input logic [IXC_CHG_CNT_W-1:0] v);
    return (v == IXC_CHG_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ixc_assign_pipe.sv
// Valid+data shift register of DEPTH stages; stage 0 captures data only on a valid input,
// valid bits shift every cycle so bubbles propagate.
module ixc_assign_pipe #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign o_vld  = r_vld[DEPTH-1];
  assign o_data = r_data[DEPTH-1];

endmodule

// File: rtl/ixc_assign_fr.sv
// Registered assign L <= R through a DEPTH-stage pipeline with per-bit force/release,
// one-shot deposit and a saturating count of cycles in which L changed.
// Handshake: i_r_vld qualifies i_r each cycle (no ready, no back-pressure); o_l_vld is
// high for exactly the cycle after the pipeline delivered a sample into o_l.
module ixc_assign_fr
  import ixc_assign_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_r,
  input  logic                     i_r_vld,
  input  logic                     i_force_en,
  input  logic [WIDTH-1:0]         i_force_val,
  input  logic [WIDTH-1:0]         i_force_mask,
  input  logic                     i_release,
  input  logic                     i_deposit,
  input  logic [WIDTH-1:0]         i_deposit_val,
  output logic [WIDTH-1:0]         o_l,
  output logic                     o_l_vld,
  output logic                     o_forced,
  output logic [IXC_CHG_CNT_W-1:0] o_chg_cnt,
  output ixc_fr_state_e            o_dbg_state
);

  logic                     w_pipe_vld;
  logic [WIDTH-1:0]         w_pipe_data;
  ixc_fr_state_e            r_state;
  ixc_fr_state_e            w_state_next;
  logic [WIDTH-1:0]         r_fmask;
  logic [WIDTH-1:0]         r_fval;
  logic [WIDTH-1:0]         w_ovr_mask;
  logic [WIDTH-1:0]         w_base;
  logic [WIDTH-1:0]         w_l_next;
  logic [WIDTH-1:0]         r_l;
  logic                     r_l_vld;
  logic                     r_forced;
  logic [IXC_CHG_CNT_W-1:0] r_chg_cnt;

  ixc_assign_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_pipe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (i_r_vld),
    .i_data (i_r),
    .o_vld  (w_pipe_vld),
    .o_data (w_pipe_data)
  );

  // force_en outranks release, so a simultaneous pair lands in FORCE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PASS: begin
        if (i_force_en) w_state_next = FORCE;
      end
      FORCE: begin
        if (i_force_en)     w_state_next = FORCE;
        else if (i_release) w_state_next = PASS;
      end
      default: w_state_next = PASS;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PASS;
      r_fmask <= '0;
      r_fval  <= '0;
    end else begin
      r_state <= w_state_next;
      if (i_force_en) begin
        r_fmask <= i_force_mask;
        r_fval  <= i_force_val;
      end else if (i_release) begin
        r_fmask <= '0;
        r_fval  <= '0;
      end
    end
  end

  // Override uses the registered state, so a force takes effect one edge after force_en.
  always_comb begin
    w_ovr_mask = (r_state == FORCE) ? r_fmask : '0;
    if (i_deposit)       w_base = i_deposit_val;
    else if (w_pipe_vld) w_base = w_pipe_data;
    else                 w_base = r_l;
    w_l_next = (w_base & ~w_ovr_mask) | (r_fval & w_ovr_mask);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_l       <= '0;
      r_l_vld   <= 1'b0;
      r_forced  <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      r_l      <= w_l_next;
      r_l_vld  <= w_pipe_vld;
      r_forced <= (r_state == FORCE);
      if (w_l_next != r_l) begin
        r_chg_cnt <= ixc_sat_inc(r_chg_cnt);
      end
    end
  end

  assign o_l         = r_l;
  assign o_l_vld     = r_l_vld;
  assign o_forced    = r_forced;
  assign o_chg_cnt   = r_chg_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ixc_assign_fr.sv
// Directed bench: a vector table drives a DEPTH=3 instance through passthrough, force,
// release, deposit and priority cases; hand sequences cover async reset and saturation.
module tb_ixc_assign_fr;
  import ixc_assign_pkg::*;

  localparam int W = 9;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] r_in, fval, fmask, dval;
  logic         r_vld, fen, rel, dep;

  logic [W-1:0]  l3, l4;
  logic          lv3, lv4, f3, f4;
  logic [15:0]   c3, c4;
  ixc_fr_state_e st3, st4;

  int total = 0;
  int bad   = 0;

  ixc_assign_fr #(.WIDTH(W), .DEPTH(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_r(r_in), .i_r_vld(r_vld),
    .i_force_en(fen), .i_force_val(fval), .i_force_mask(fmask),
    .i_release(rel), .i_deposit(dep), .i_deposit_val(dval),
    .o_l(l3), .o_l_vld(lv3), .o_forced(f3), .o_chg_cnt(c3), .o_dbg_state(st3)
  );

  ixc_assign_fr #(.WIDTH(W), .DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_r(r_in), .i_r_vld(r_vld),
    .i_force_en(fen), .i_force_val(fval), .i_force_mask(fmask),
    .i_release(rel), .i_deposit(dep), .i_deposit_val(dval),
    .o_l(l4), .o_l_vld(lv4), .o_forced(f4), .o_chg_cnt(c4), .o_dbg_state(st4)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         vld;
    logic         fen;
    logic [W-1:0] fval;
    logic [W-1:0] fmask;
    logic         rel;
    logic         dep;
    logic [W-1:0] dval;
    logic [W-1:0] exp_l;
    logic         exp_lv;
    logic         exp_forced;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t vecs [34];

  function automatic vec_t mk(logic [W-1:0] r, logic vld, logic fen_i, logic [W-1:0] fv,
                              logic [W-1:0] fm, logic rel_i, logic dep_i, logic [W-1:0] dv,
                              logic [W-1:0] el, logic elv, logic ef, logic [15:0] ec);
    vec_t v;
    v.r = r; v.vld = vld; v.fen = fen_i; v.fval = fv; v.fmask = fm; v.rel = rel_i;
    v.dep = dep_i; v.dval = dv; v.exp_l = el; v.exp_lv = elv; v.exp_forced = ef; v.exp_cnt = ec;
    return v;
  endfunction

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    r_in = '0; r_vld = 1'b0; fen = 1'b0; fval = '0; fmask = '0;
    rel = 1'b0; dep = 1'b0; dval = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("reset_l3", 32'(l3), 0);
    chk("reset_lv3", 32'(lv3), 0);
    chk("reset_forced3", 32'(f3), 0);
    chk("reset_cnt3", 32'(c3), 0);
    chk("reset_state3", 32'(st3), 32'(PASS));
    chk("reset_l4", 32'(l4), 0);
    rst = 1'b0;

    //          r       vld fen fval    fmask   rel dep dval    exp_l   lv f  cnt
    vecs[0]  = mk(9'h1A5, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    vecs[1]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    vecs[2]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 0);
    vecs[3]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1A5, 1, 0, 1);
    vecs[4]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1A5, 0, 0, 1);
    vecs[5]  = mk(9'h1FF, 1, 1, 9'h005, 9'h00F, 0, 0, 9'h000, 9'h1A5, 0, 0, 1);
    vecs[6]  = mk(9'h1FF, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1A5, 0, 1, 1);
    vecs[7]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1A5, 0, 1, 1);
    vecs[8]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1F5, 1, 1, 2);
    vecs[9]  = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1F5, 1, 1, 2);
    vecs[10] = mk(9'h000, 0, 0, 9'h000, 9'h000, 1, 0, 9'h000, 9'h1F5, 0, 1, 2);
    vecs[11] = mk(9'h000, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1F5, 0, 0, 2);
    vecs[12] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1F5, 0, 0, 2);
    vecs[13] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h1F5, 0, 0, 2);
    vecs[14] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h000, 1, 0, 3);
    vecs[15] = mk(9'h000, 0, 1, 9'h0AA, 9'h1FF, 1, 0, 9'h000, 9'h000, 0, 0, 3);
    vecs[16] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h0AA, 0, 1, 4);
    vecs[17] = mk(9'h000, 0, 1, 9'h000, 9'h100, 0, 0, 9'h000, 9'h0AA, 0, 1, 4);
    vecs[18] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 1, 9'h1FF, 9'h0FF, 0, 1, 5);
    vecs[19] = mk(9'h001, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h0FF, 0, 1, 5);
    vecs[20] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h0FF, 0, 1, 5);
    vecs[21] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h0FF, 0, 1, 5);
    vecs[22] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h001, 1, 1, 6);
    vecs[23] = mk(9'h000, 0, 0, 9'h000, 9'h000, 1, 0, 9'h000, 9'h001, 0, 1, 6);
    vecs[24] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h001, 0, 0, 6);
    vecs[25] = mk(9'h155, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h001, 0, 0, 6);
    vecs[26] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h001, 0, 0, 6);
    vecs[27] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 1, 9'h0F0, 9'h0F0, 0, 0, 7);
    vecs[28] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h155, 1, 0, 8);
    vecs[29] = mk(9'h0AB, 1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h155, 0, 0, 8);
    vecs[30] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h155, 0, 0, 8);
    vecs[31] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h155, 0, 0, 8);
    vecs[32] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 1, 9'h123, 9'h123, 1, 0, 9);
    vecs[33] = mk(9'h000, 0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 9'h123, 0, 0, 9);

    for (int i = 0; i < 34; i++) begin
      r_in = vecs[i].r; r_vld = vecs[i].vld; fen = vecs[i].fen; fval = vecs[i].fval;
      fmask = vecs[i].fmask; rel = vecs[i].rel; dep = vecs[i].dep; dval = vecs[i].dval;
      step();
      chk($sformatf("vec%0d_l", i), 32'(l3), 32'(vecs[i].exp_l));
      chk($sformatf("vec%0d_lvld", i), 32'(lv3), 32'(vecs[i].exp_lv));
      chk($sformatf("vec%0d_forced", i), 32'(f3), 32'(vecs[i].exp_forced));
      chk($sformatf("vec%0d_cnt", i), 32'(c3), 32'(vecs[i].exp_cnt));
    end

    // DEPTH=4 latency, then async reset with three samples in flight
    reset_pulse();
    r_in = 9'h1A5; r_vld = 1'b1;
    step();
    idle_inputs();
    step(); step(); step();
    chk("d4_lat_early_l", 32'(l4), 0);
    chk("d4_lat_early_lvld", 32'(lv4), 0);
    step();
    chk("d4_lat_l", 32'(l4), 32'h1A5);
    chk("d4_lat_lvld", 32'(lv4), 1);
    chk("d4_lat_cnt", 32'(c4), 1);
    r_vld = 1'b1;
    r_in = 9'h011; step();
    r_in = 9'h022; step();
    r_in = 9'h033; step();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_async_l4", 32'(l4), 0);
    chk("rst_async_cnt4", 32'(c4), 0);
    chk("rst_async_lvld4", 32'(lv4), 0);
    chk("rst_async_l3", 32'(l3), 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rst_flush%0d_lvld4", i), 32'(lv4), 0);
      chk($sformatf("rst_flush%0d_l4", i), 32'(l4), 0);
      chk($sformatf("rst_flush%0d_cnt4", i), 32'(c4), 0);
    end

    // counter saturation
    reset_pulse();
    r_vld = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      r_in = 9'(i & 1);
      step();
    end
    chk("sat_cnt3", 32'(c3), 32'(IXC_CHG_CNT_MAX));
    chk("sat_cnt4", 32'(c4), 32'hFFFF);
    for (int i = 0; i < 5; i++) begin
      r_in = 9'(i & 1);
      step();
      chk($sformatf("sat_hold%0d_cnt3", i), 32'(c3), 32'hFFFF);
    end
    idle_inputs();

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ixc_assign_fr.md
# ixc_assign_fr

Parametrised, registered successor to the bit-wise `ixc_assign` templates in `IXCOM_TEMP_LIBRARY`. It drives `L` from `R` through a configurable pipeline of `DEPTH` register stages. It adds per-bit force/release and one-shot deposit, giving emulation-side signal override without editing the user netlist. A saturating change counter supports waveform-less activity debug.

## Interface
- `WIDTH`, default 9: data width of `R`, `L`, `force_val`, `force_mask`, `deposit_val`; legal range 1..1024.
- `DEPTH`, default 1: pipeline stages from `R` to `L`; legal range 1..8.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `R` input WIDTH: source data.
- `r_vld` input 1: `R` is valid this cycle.
- `force_en` input 1: pulse; latch `force_val`/`force_mask` and enter FORCE.
- `force_val` input WIDTH: forced bit values.
- `force_mask` input WIDTH: 1 = bit forced.
- `release` input 1: pulse; leave FORCE.
- `deposit` input 1: pulse; one-shot load of `deposit_val` into `L`.
- `deposit_val` input WIDTH: value to deposit.
- `L` output WIDTH: assigned value, registered.
- `l_vld` output 1: `L` was updated from the pipeline this cycle.
- `forced` output 1: high while in FORCE.
- `chg_cnt` output 16: count of cycles in which `L` changed value, saturating.

## Operation
- Pipeline: `DEPTH` stages of {vld, data}. The stage-0 data register loads only when `r_vld`=1. Valid bits shift every cycle; bubbles propagate.
- FSM, two states:
  - PASS (reset state):
    - `force_en` → FORCE.
    - `release` is ignored.
  - FORCE:
    - `release` → PASS.
    - `force_en` re-latches the mask and value, staying in FORCE.
- Held registers `fmask`/`fval` are latched on `force_en` and cleared to 0 on `release` and on reset.
- `L` next-value priority per bit, highest first:
  1. `rst`: `L` = 0.
  2. Forced bit (`fmask`=1 in FORCE): `fval`.
  3. `deposit`=1: `deposit_val` bit.
  4. Pipeline output valid: pipeline data bit.
  5. Otherwise: hold.
- `force_en` and `release` asserted together: `force_en` wins; FSM is FORCE next cycle with the new mask.
- Deposit in FORCE alters unmasked bits only. Deposit does not stall or flush the pipeline, so a later pipeline valid overwrites the deposited value.
- `l_vld` = pipeline output valid, registered alongside `L`. It is asserted even when all bits are forced.
- `chg_cnt` increments when the registered `L` differs from its previous value, and saturates at 0xFFFF.
- `forced` = (state == FORCE), registered.

## Timing
- Reset values:
  - `L` = 0, `l_vld` = 0, `forced` = 0, `chg_cnt` = 0.
  - All pipeline valid and data bits = 0; FSM = PASS.
- Data latency: `R` sampled at edge N with `r_vld` appears on `L` with `l_vld`=1 after edge N+DEPTH.
- Force latency: `force_en` at edge N overrides `L` and sets `forced` after edge N+1. Pipeline data in flight continues to advance underneath.
- Release latency: `release` at edge N clears `forced` after edge N+1. `L` then holds until the next pipeline valid or deposit; it does not revert instantly.
- Deposit latency: 1 cycle.
- Reset mid-operation clears in-flight pipeline data immediately, asynchronously; no `l_vld` is produced for pre-reset samples.
- Throughput: one sample per cycle, with no back-pressure.

## Structure
- Package `ixc_assign_pkg` holds:
  - state enum `ixc_fr_state_e` {PASS, FORCE};
  - `IXC_CHG_CNT_W` = 16;
  - `IXC_CHG_CNT_MAX`.
- Sub-module `ixc_assign_pipe`, parameters WIDTH and DEPTH: a valid+data shift register with asynchronous reset. The top level holds the FSM, the override mux, the `L` register and the counter.

## Test plan
- Passthrough, WIDTH=9, DEPTH=3: `R`=0x1A5 with `r_vld` at cycle 0 → `L`=0x1A5 and `l_vld`=1 after edge 3; `chg_cnt`=1.
- Force mask: `force_en`, `force_mask`=0x00F, `force_val`=0x005; then stream `R`=0x1FF → `L`=0x1F5 and `forced`=1. `release`, then `R`=0x000 → `L`=0x000 after DEPTH cycles and `forced`=0.
- Simultaneous `force_en`+`release` in PASS, mask 0x1FF, value 0x0AA → next cycle `forced`=1, `L`=0x0AA.
- Deposit in FORCE with mask 0x100, `fval`=0; `deposit_val`=0x1FF → `L`=0x0FF one cycle later. The next valid `R`=0x001 → `L`=0x001.
- Reset mid-stream, DEPTH=4: three samples in flight, `rst` pulsed → `L`=0, `l_vld` stays 0 for 4 cycles, `chg_cnt`=0.
- Counter saturation: toggle `R` between 0 and 1 every cycle for 70000 cycles → `chg_cnt`=0xFFFF and stays there.
